vga_line_fetch: RTL and testbench
=================================

# vga_line_fetch

Scanline prefetch stage that sits directly upstream of the VGA controller `vgac` and drives its 24-bit pixel input. It holds two line buffers in a ping-pong arrangement. While `vgac` reads one bank by `col_addr`, the block fetches the next display row from frame memory into the other bank over a req/ack word port. Banks swap at the end of each active line, which wraps row 479 to row 0 so that row 0 is fetched during vertical blank.

## Interface
- `H_PIX`, 640, active pixels per line (line-buffer depth).
- `V_PIX`, 480, active rows per frame.
- `DW`, 24, pixel width (8:8:8 RGB).
- `AW`, 19, frame-memory word address width; must satisfy H_PIX*V_PIX ≤ 2^AW.
- `vga_clk`  in  1  pixel clock; the only clock.
- `clr`  in  1  reset; synchronous, active-high.
- `row_addr`  in  9  current row from `vgac`.
- `col_addr`  in  10  current column from `vgac`.
- `rdn`  in  1  `vgac` read strobe; low during active pixels.
- `pix_data`  out  DW  pixel for `col_addr`; connects to `vgac` `d_in`.
- `mem_req`  out  1  word request to frame memory.
- `mem_addr`  out  AW  word address; the value is row*H_PIX + col.
- `mem_ack`  in  1  memory has returned `mem_data` for `mem_addr` this cycle.
- `mem_data`  in  DW  returned word.
- `fetch_busy`  out  1  a fetch is in progress.
- `underrun_cnt`  out  8  saturating underrun count; present only with `VGA_LINE_FETCH_UNDERRUN_EN`.

## Operation
- Storage: two banks, each H_PIX×DW. `disp_sel` selects the display bank and the other bank is the back bank.
- `pix_data` is an asynchronous read of `display[col_addr]`. When `col_addr ≥ H_PIX`, the output is 0. Bank contents are not reset.
- `row_q` captures `row_addr` on every cycle with `rdn`=0.
- Line-end event: `line_end = rdn & ~rdn_q`, where `rdn_q` is `rdn` registered.
- Next row: `nrow = (row_q == V_PIX-1) ? 0 : row_q+1`.
- FSM states:
  - **INIT**: entered on reset. Moves to FETCH unconditionally on the next cycle with row=0 and idx=0.
  - **FETCH**: `mem_req`=1 and `mem_addr` = base + idx, where base = row*H_PIX is computed by shift-add and registered at fetch start. On `mem_ack`, the block writes `mem_data` to `back[idx]` and increments idx. An ack with idx==H_PIX-1 sets `ready`=1 and moves to IDLE.
  - **IDLE**: `mem_req`=0; the block waits for `line_end`.
- `line_end` with `ready`=1: toggle `disp_sel`, clear `ready`, and start FETCH for `nrow`.
- `line_end` while in FETCH (underrun): no swap, so the display bank repeats its row. The fetch is aborted and restarted at idx=0 for `nrow`, and `underrun_cnt` increments if the feature is compiled in.
- If the final `mem_ack` and `line_end` fall in the same cycle, the fetch counts as complete and the swap proceeds.
- `line_end` in INIT is ignored.
- `fetch_busy` is 1 in INIT and FETCH.
- `mem_addr` and `mem_req` are held stable until `mem_ack`. An ack received while `mem_req`=0 is ignored.

## Timing
- Reset values: `mem_req`=0, `mem_addr`=0, `fetch_busy`=1 (INIT), `ready`=0, `disp_sel`=0, `underrun_cnt`=0. `pix_data` follows the unreset bank content, so it is undefined until the first swap.
- `clr` asserted mid-fetch: `mem_req` is 0 in the following cycle and any late ack is dropped.
- FETCH begins the cycle after INIT or after the `line_end` edge. The first `mem_req` is visible one cycle after `line_end` is sampled.
- Swap latency: `pix_data` reads the new bank from the cycle after the `line_end` edge.
- Throughput: one word per `mem_ack`, zero-wait ack allowed, so H_PIX words take at least H_PIX cycles. Memory must sustain ≥640 acks per 800-cycle line.
- `pix_data` has no pipeline delay: it is valid in the same cycle as `col_addr`.

## Configuration
- `VGA_LINE_FETCH_UNDERRUN_EN` defined: the `underrun_cnt` port and its 8-bit counter exist. The counter increments once per underrun event and saturates at 255; only reset clears it.
- Undefined: the port and counter are omitted. Underrun behaviour (no swap, fetch restart) is unchanged.

## Structure
- Shared package `vga_pkg`: H_PIX/V_PIX defaults, the DW/AW constants, and the FSM state encoding (INIT, FETCH, IDLE).
- One sub-module, `line_buf`: an H_PIX×DW RAM with a synchronous write port and an asynchronous read port, instantiated twice.

## Test plan
- **Reset then zero-wait memory** (ack=1 always): `mem_addr` steps 0..639 over 640 cycles, then `fetch_busy`=0 and `mem_req`=0.
- **Row 5 display then line end**: with `row_q`=5, `line_end` swaps banks. The next fetch starts at `mem_addr`=3840 and ends at 4479. `pix_data` at `col_addr`=7 equals the word stored at address 7 of row 5's prefetch.
- **Frame wrap**: line end with `row_q`=479 → fetch starts at `mem_addr`=0.
- **Slow memory** (ack every 2nd cycle, 800-cycle line): underrun occurs, the display row repeats, the fetch restarts at idx 0, and `underrun_cnt`=1. When the macro is undefined, the port is absent.
- **Last ack in the same cycle as `line_end`**: the swap happens and `underrun_cnt` is unchanged.
- **`clr` pulsed mid-fetch at idx 300**: `mem_req`=0 the next cycle, then a fresh fetch of row 0 starting at `mem_addr`=0. Out-of-range `col_addr`=700 gives `pix_data`=0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants, FSM encoding and row-base helper for the VGA scanline prefetch stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package vga_pkg;

  localparam int unsigned H_PIX_DEF = 640;  // active pixels per line
  localparam int unsigned V_PIX_DEF = 480;  // active rows per frame
  localparam int unsigned DW_DEF    = 24;   // 8:8:8 RGB pixel
  localparam int unsigned AW_DEF    = 19;   // frame-memory word address width

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_IDLE  = 2'd2
  } fetch_state_e;

  // row * hpix built from shifted copies of row, one per set bit of hpix,
  // so the constant multiply collapses to a small adder tree.
  function automatic logic [31:0] row_base(input logic [31:0] row, input int unsigned hpix);
    logic [31:0] acc;
    acc = '0;
    for (int b = 0; b < 32; b++) begin
      if (hpix[b]) acc = acc + (row << b);
    end
    return acc;
  endfunction

endpackage

// File: rtl/line_buf.sv
// One scanline of pixel storage: synchronous write port, asynchronous read port.
// Latency: write lands on the next clock edge; read is combinational.
// Backpressure: none; the writer owns the write strobe.
module line_buf #(
  parameter int unsigned DEPTH = 640,
  parameter int unsigned DW    = 24,
  parameter int unsigned IW    = 10
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [IW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [IW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  // Store one pixel word when the fetch engine strobes a write.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/vga_line_fetch.sv
// Ping-pong scanline prefetch in front of vgac: displays one bank while fetching the next row into the other.
// Latency: pix_data is combinational from col_addr; banks swap on the edge that samples the rdn rising edge.
// Backpressure: mem_req/mem_addr held until mem_ack; a late line end aborts and restarts the fetch (underrun).
// Optional underrun counter port enabled by defining VGA_LINE_FETCH_UNDERRUN_EN.
module vga_line_fetch
  import vga_pkg::*;
#(
  parameter int unsigned H_PIX = H_PIX_DEF,
  parameter int unsigned V_PIX = V_PIX_DEF,
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned AW    = AW_DEF
) (
  input  logic          vga_clk,
  input  logic          clr,
  input  logic [8:0]    row_addr,
  input  logic [9:0]    col_addr,
  input  logic          rdn,
  output logic [DW-1:0] pix_data,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_data,
  output logic          fetch_busy
`ifdef VGA_LINE_FETCH_UNDERRUN_EN
  ,
  output logic [7:0]    underrun_cnt
`endif
);

  localparam int unsigned IW       = $clog2(H_PIX);
  localparam logic [IW-1:0] IDX_LAST = IW'(H_PIX - 1);
  localparam logic [8:0]    ROW_LAST = 9'(V_PIX - 1);
  localparam logic [9:0]    COL_LIM  = 10'(H_PIX);

  fetch_state_e  state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [AW-1:0] base_q, base_d;
  logic          ready_q, ready_d;
  logic          disp_sel_q, disp_sel_d;
  logic [8:0]    row_q;
  logic          rdn_q;

  logic          line_end;
  logic          last_ack;
  logic [8:0]    nrow;
  logic [AW-1:0] nbase;
  logic          buf_we;
  logic [DW-1:0] rd0, rd1;

  assign line_end = rdn & ~rdn_q;
  assign nrow     = (row_q == ROW_LAST) ? 9'd0 : row_q + 9'd1;
  assign nbase    = AW'(row_base(32'(nrow), H_PIX));
  assign last_ack = (state_q == ST_FETCH) && mem_ack && (idx_q == IDX_LAST);

  // Track the display row and the rdn history that defines the line-end edge.
  always_ff @(posedge vga_clk) begin
    if (clr) begin
      row_q <= '0;
      rdn_q <= 1'b1;
    end else begin
      if (!rdn) row_q <= row_addr;
      rdn_q <= rdn;
    end
  end

  // Fetch engine state and bank-select registers.
  always_ff @(posedge vga_clk) begin
    if (clr) begin
      state_q    <= ST_INIT;
      idx_q      <= '0;
      base_q     <= '0;
      ready_q    <= 1'b0;
      disp_sel_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      base_q     <= base_d;
      ready_q    <= ready_d;
      disp_sel_q <= disp_sel_d;
    end
  end

  // Next-state: walk the back bank word by word; a line end either swaps (fetch done) or restarts (underrun).
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    base_d     = base_q;
    ready_d    = ready_q;
    disp_sel_d = disp_sel_q;
    case (state_q)
      ST_INIT: begin
        // Row 0 is fetched straight out of reset; any line end here is ignored.
        state_d = ST_FETCH;
        idx_d   = '0;
        base_d  = '0;
      end
      ST_FETCH: begin
        if (line_end) begin
          // A final ack coinciding with the line end still counts as a complete line.
          if (last_ack) disp_sel_d = ~disp_sel_q;
          state_d = ST_FETCH;
          idx_d   = '0;
          base_d  = nbase;
          ready_d = 1'b0;
        end else if (mem_ack) begin
          if (idx_q == IDX_LAST) begin
            state_d = ST_IDLE;
            ready_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_IDLE: begin
        if (line_end && ready_q) begin
          disp_sel_d = ~disp_sel_q;
          ready_d    = 1'b0;
          state_d    = ST_FETCH;
          idx_d      = '0;
          base_d     = nbase;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  assign mem_req    = (state_q == ST_FETCH);
  assign mem_addr   = base_q + AW'(idx_q);
  assign fetch_busy = (state_q != ST_IDLE);

  // Acks only count while a request is outstanding; the back bank is the one not on display.
  assign buf_we = mem_req & mem_ack;

  line_buf #(.DEPTH(H_PIX), .DW(DW), .IW(IW)) u_bank0 (
    .clk_i   (vga_clk),
    .we_i    (buf_we & disp_sel_q),
    .waddr_i (idx_q),
    .wdata_i (mem_data),
    .raddr_i (col_addr[IW-1:0]),
    .rdata_o (rd0)
  );

  line_buf #(.DEPTH(H_PIX), .DW(DW), .IW(IW)) u_bank1 (
    .clk_i   (vga_clk),
    .we_i    (buf_we & ~disp_sel_q),
    .waddr_i (idx_q),
    .wdata_i (mem_data),
    .raddr_i (col_addr[IW-1:0]),
    .rdata_o (rd1)
  );

  assign pix_data = (col_addr < COL_LIM) ? (disp_sel_q ? rd1 : rd0) : '0;

`ifdef VGA_LINE_FETCH_UNDERRUN_EN
  logic       underrun_evt;
  logic [7:0] urun_q;

  assign underrun_evt = (state_q == ST_FETCH) && line_end && !last_ack;

  // Saturating count of lines whose prefetch missed the line end.
  always_ff @(posedge vga_clk) begin
    if (clr) begin
      urun_q <= '0;
    end else if (underrun_evt && (urun_q != 8'hFF)) begin
      urun_q <= urun_q + 8'd1;
    end
  end

  assign underrun_cnt = urun_q;
`endif

endmodule

// File: tb/tb_vga_line_fetch.sv
// Randomized line-level bench for vga_line_fetch with a row/word reference model and decoupled scoreboard.
// Latency: expectations are queued per cycle by the driver and popped by the monitor on the falling edge.
// Backpressure: memory acks are generated by the bench (zero-wait, slow, aligned, random).
module tb_vga_line_fetch;

  localparam int HP = 640;
  localparam int VP = 480;

  logic        vga_clk = 1'b0;
  logic        clr;
  logic [8:0]  row_addr;
  logic [9:0]  col_addr;
  logic        rdn;
  logic [23:0] pix_data;
  logic        mem_req;
  logic [18:0] mem_addr;
  logic        mem_ack;
  logic [23:0] mem_data;
  logic        fetch_busy;
`ifdef VGA_LINE_FETCH_UNDERRUN_EN
  logic [7:0]  underrun_cnt;
`endif

  always #5 vga_clk = ~vga_clk;

  vga_line_fetch dut (
    .vga_clk    (vga_clk),
    .clr        (clr),
    .row_addr   (row_addr),
    .col_addr   (col_addr),
    .rdn        (rdn),
    .pix_data   (pix_data),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_data   (mem_data),
    .fetch_busy (fetch_busy)
`ifdef VGA_LINE_FETCH_UNDERRUN_EN
    ,
    .underrun_cnt (underrun_cnt)
`endif
  );

  // Frame memory content: a fixed scramble of the word address.
  function automatic logic [23:0] mdat(input int unsigned a);
    int unsigned h;
    h = a * 32'h9E3779B1 + 32'h1234;
    h = h ^ (h >> 11);
    return h[23:0];
  endfunction

  assign mem_data = mdat(32'(mem_addr));

  typedef struct {
    bit          pix_chk;
    logic [23:0] pix;
    bit          busy;
    bit          req;
    int          urun;
    bit          addr0_chk;
  } exp_t;

  exp_t exp_q[$];
  int   addr_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   started = 0;
  bit   done = 0;

  // Reference model: which row is on display, which row is being fetched and how far.
  bit m_init = 1, m_fetch = 0, m_ready = 0;
  int m_row = 0, m_cnt = 0, m_disp = -1, m_urun = 0, m_rowq = 0;
  bit p_rdn = 1, p_rdn_q = 1, p_ack = 1, p_clr = 1;
  int p_row = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic start_fetch(input int r);
    m_fetch = 1;
    m_row   = r;
    m_cnt   = 0;
    addr_q.delete();
    for (int k = 0; k < HP; k++) addr_q.push_back(r * HP + k);
  endtask

  // One pixel clock: account for the edge just taken, then drive the next cycle's inputs and queue expectations.
  task automatic cycle(input bit rdn_v, input int row_v, input int col_v, input bit ack_v, input bit clr_v);
    bit   le, done_now;
    int   nrow;
    exp_t e;
    @(posedge vga_clk);
    #1;
    if (p_clr) begin
      m_init = 1; m_fetch = 0; m_ready = 0; m_disp = -1; m_urun = 0; m_rowq = 0;
      addr_q.delete();
    end else begin
      le   = p_rdn && !p_rdn_q;
      nrow = (m_rowq == VP - 1) ? 0 : m_rowq + 1;
      if (m_init) begin
        m_init = 0;
        start_fetch(0);
      end else begin
        done_now = m_fetch && p_ack && (m_cnt == HP - 1);
        if (m_fetch && p_ack) m_cnt++;
        if (le && (done_now || (!m_fetch && m_ready))) begin
          m_disp  = m_row;
          m_ready = 0;
          start_fetch(nrow);
        end else if (le && m_fetch) begin
          if (m_urun < 255) m_urun++;
          start_fetch(nrow);
        end else if (done_now) begin
          m_fetch = 0;
          m_ready = 1;
        end
      end
      if (!p_rdn) m_rowq = p_row;
    end
    clr      = clr_v;
    rdn      = rdn_v;
    row_addr = 9'(row_v);
    col_addr = 10'(col_v);
    mem_ack  = ack_v;
    e.busy      = m_init || m_fetch;
    e.req       = m_fetch;
    e.urun      = m_urun;
    e.addr0_chk = m_init;
    e.pix_chk   = (col_v >= HP) || (m_disp >= 0);
    e.pix       = 24'h0;
    if (col_v < HP && m_disp >= 0) e.pix = mdat(32'(m_disp * HP + col_v));
    exp_q.push_back(e);
    started = 1;
    p_rdn_q = p_rdn;
    p_rdn   = rdn_v;
    p_row   = row_v;
    p_ack   = ack_v;
    p_clr   = clr_v;
  endtask

  // One 800-cycle line: 160 blank cycles (line end on the first), then 640 active cycles.
  // mode 0 zero-wait, 1 ack every 2nd cycle, 2 last ack lands on the next line end, 3 random 7/8.
  task automatic run_line(input int row, input int mode, input int clr_c);
    bit ack;
    for (int c = 0; c < 800; c++) begin
      case (mode)
        0:       ack = 1'b1;
        1:       ack = (c % 2 == 0);
        2:       ack = (c >= 161) || (c == 0);
        default: ack = ($urandom_range(0, 7) != 0);
      endcase
      cycle(c < 160, row, (c < 160) ? 640 + c : c - 160, ack, c == clr_c);
    end
  endtask

  // Monitor: pop one expectation per cycle and compare; accepted acks are matched against the address stream.
  initial begin
    exp_t e;
    wait (started);
    forever begin
      @(negedge vga_clk);
      if (done) break;
      if (exp_q.size() == 0) begin
        chk("exp_queue_empty", 32'd1, 32'd0);
        continue;
      end
      e = exp_q.pop_front();
      chk("fetch_busy", 32'(fetch_busy), 32'(e.busy));
      chk("mem_req", 32'(mem_req), 32'(e.req));
`ifdef VGA_LINE_FETCH_UNDERRUN_EN
      chk("underrun_cnt", 32'(underrun_cnt), 32'(e.urun));
`endif
      if (e.addr0_chk) chk("mem_addr_init", 32'(mem_addr), 32'd0);
      if (e.pix_chk) chk("pix_data", 32'(pix_data), 32'(e.pix));
      if (mem_req === 1'b1 && mem_ack === 1'b1) begin
        if (addr_q.size() == 0) begin
          chk("unexpected_ack_addr", 32'(mem_addr), 32'hFFFFFFFF);
        end else begin
          chk("mem_addr", 32'(mem_addr), 32'(addr_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1'b1; rdn = 1'b1; row_addr = '0; col_addr = 10'd700; mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b1, 0, 700, 1'b1, 1'b1);
    run_line(4, 0, -1);     // reset fetch of row 0 with zero-wait memory
    run_line(5, 0, -1);
    run_line(6, 3, -1);     // row 5 ends: fetch of row 6 at 3840
    run_line(479, 0, -1);
    run_line(0, 2, -1);     // row 479 ends: fetch wraps to row 0
    run_line(1, 2, -1);     // final ack on the line end
    run_line(2, 1, -1);     // slow memory: underrun
    run_line(3, 1, -1);
    run_line(4, 0, -1);
    run_line(10, 0, 301);   // clr at fetch index 300
    run_line(11, 0, -1);
    run_line(12, 0, -1);
    for (int n = 0; n < 6; n++) begin
      run_line($urandom_range(0, VP - 1), ($urandom_range(0, 1) == 0) ? 0 : 3, -1);
    end
    @(posedge vga_clk);
    #1;
    done = 1;
    #20;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
